// File: rtl/hit_arbiter.sv
// Owns both players' health registers and serialises hit requests into one damage path.
// Optional GUARD_EN: a victim holding its block input during APPLY absorbs the hit.
module hit_arbiter #(
    parameter int HEALTH_W       = 3,
    parameter int MAX_HEALTH     = 5,
    parameter int DMG            = 1,
    parameter int INVULN_CYCLES  = 30,
    parameter int COUNTDOWN_CODE = 1,
    parameter int FIGHT_CODE     = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [2:0]          game_state,
    input  logic                p1_hit_req,
    input  logic                p2_hit_req,
    input  logic                p1_block,
    input  logic                p2_block,
    output logic [HEALTH_W-1:0] player1_health,
    output logic [HEALTH_W-1:0] player2_health,
    output logic                p1_hit_ack,
    output logic                p2_hit_ack,
    output logic                hit_landed,
    output logic                p1_invuln,
    output logic                p2_invuln
);

    localparam logic [1:0] ST_ARB     = 2'd0;
    localparam logic [1:0] ST_APPLY   = 2'd1;
    localparam logic [1:0] ST_ACK     = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    localparam int INV_W = (INVULN_CYCLES > 0) ? $clog2(INVULN_CYCLES + 1) : 1;
    localparam logic [INV_W-1:0]    INV_LOAD = INV_W'(INVULN_CYCLES);
    localparam logic [HEALTH_W-1:0] H_MAX    = HEALTH_W'(MAX_HEALTH);
    localparam logic [HEALTH_W-1:0] H_DMG    = HEALTH_W'(DMG);

    logic [1:0]          state_q, state_d;
    logic                grant_q, grant_d;   // 0: P1 attacks P2, 1: P2 attacks P1
    logic                rr_q, rr_d;         // tie owner: 0 = P1, 1 = P2
    logic                landed_q, landed_d;
    logic [HEALTH_W-1:0] h1_q, h1_d, h2_q, h2_d;
    logic [INV_W-1:0]    inv1_q, inv1_d, inv2_q, inv2_d;

    logic                in_fight, in_countdown, granted_req, hit_ok, victim_inv_zero;
    logic [HEALTH_W-1:0] victim_h, dmg_h;

    assign in_fight        = (game_state == 3'(FIGHT_CODE));
    assign in_countdown    = (game_state == 3'(COUNTDOWN_CODE));
    assign granted_req     = grant_q ? p2_hit_req : p1_hit_req;
    assign victim_h        = grant_q ? h1_q : h2_q;
    assign victim_inv_zero = grant_q ? (inv1_q == '0) : (inv2_q == '0);
    assign dmg_h           = (int'(victim_h) < DMG) ? '0 : victim_h - H_DMG;

`ifdef GUARD_EN
    logic victim_block;
    assign victim_block = grant_q ? p1_block : p2_block;
    assign hit_ok = in_fight & victim_inv_zero & (victim_h != '0) & ~victim_block;
`else
    logic unused_block;
    assign unused_block = p1_block ^ p2_block;
    assign hit_ok = in_fight & victim_inv_zero & (victim_h != '0);
`endif

    always_comb begin
        // NOTE: every next-state variable takes its hold value first so no path infers a latch.
        state_d  = state_q;
        grant_d  = grant_q;
        rr_d     = rr_q;
        landed_d = landed_q;
        h1_d     = h1_q;
        h2_d     = h2_q;
        inv1_d   = (inv1_q != '0) ? inv1_q - 1'b1 : inv1_q;
        inv2_d   = (inv2_q != '0) ? inv2_q - 1'b1 : inv2_q;

        case (state_q)
            ST_ARB: begin
                if (p1_hit_req && p2_hit_req) begin
                    grant_d = rr_q;
                    rr_d    = ~rr_q;
                    state_d = ST_APPLY;
                end else if (p1_hit_req) begin
                    grant_d = 1'b0;
                    state_d = ST_APPLY;
                end else if (p2_hit_req) begin
                    grant_d = 1'b1;
                    state_d = ST_APPLY;
                end
            end
            ST_APPLY: begin
                landed_d = hit_ok;
                if (hit_ok) begin
                    if (grant_q) begin
                        h1_d   = dmg_h;
                        inv1_d = INV_LOAD;
                    end else begin
                        h2_d   = dmg_h;
                        inv2_d = INV_LOAD;
                    end
                end
                state_d = ST_ACK;
            end
            ST_ACK:     state_d = ST_RELEASE;
            ST_RELEASE: if (!granted_req) state_d = ST_ARB;
            default:    state_d = ST_ARB;
        endcase

        // Countdown reload wins over any damage applied in the same cycle.
        if (in_countdown) begin
            h1_d   = H_MAX;
            h2_d   = H_MAX;
            inv1_d = '0;
            inv2_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset) begin
            state_q  <= ST_ARB;
            grant_q  <= 1'b0;
            rr_q     <= 1'b0;
            landed_q <= 1'b0;
            h1_q     <= H_MAX;
            h2_q     <= H_MAX;
            inv1_q   <= '0;
            inv2_q   <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_q     <= rr_d;
            landed_q <= landed_d;
            h1_q     <= h1_d;
            h2_q     <= h2_d;
            inv1_q   <= inv1_d;
            inv2_q   <= inv2_d;
        end
    end

    assign player1_health = h1_q;
    assign player2_health = h2_q;
    assign p1_hit_ack     = (state_q == ST_ACK) & ~grant_q;
    assign p2_hit_ack     = (state_q == ST_ACK) &  grant_q;
    assign hit_landed     = (state_q == ST_ACK) &  landed_q;
    assign p1_invuln      = (inv1_q != '0);
    assign p2_invuln      = (inv2_q != '0);

endmodule

// File: tb/tb_hit_arbiter.sv
// Self-checking bench for hit_arbiter: directed hand sequences plus a table of hit transactions.
// Expectations for the guarded rows follow GUARD_EN when the bench is built with it.
module tb_hit_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] game_state;
    logic       p1_hit_req, p2_hit_req, p1_block, p2_block;
    logic [2:0] player1_health, player2_health;
    logic       p1_hit_ack, p2_hit_ack, hit_landed, p1_invuln, p2_invuln;

    int n_cmp  = 0;
    int n_fail = 0;

`ifdef GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    hit_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .game_state    (game_state),
        .p1_hit_req    (p1_hit_req),
        .p2_hit_req    (p2_hit_req),
        .p1_block      (p1_block),
        .p2_block      (p2_block),
        .player1_health(player1_health),
        .player2_health(player2_health),
        .p1_hit_ack    (p1_hit_ack),
        .p2_hit_ack    (p2_hit_ack),
        .hit_landed    (hit_landed),
        .p1_invuln     (p1_invuln),
        .p2_invuln     (p2_invuln)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic [2:0] gs;
        int         who;
        logic       p1_blk;
        logic       p2_blk;
        int         pre_wait;
        logic       exp_landed;
        int         exp_h1;
        int         exp_h2;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for the ack of `who`; flags if the other player's ack shows up first.
    task automatic wait_ack(input int who, output logic ok, output logic landed, output logic wrong);
        ok = 1'b0; landed = 1'b0; wrong = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            if ((who == 1) ? p1_hit_ack : p2_hit_ack) begin
                ok     = 1'b1;
                landed = hit_landed;
            end else if ((who == 1) ? p2_hit_ack : p1_hit_ack) begin
                wrong = 1'b1;
            end
        end
    endtask

    task automatic hit(input int who, output logic ok, output logic landed);
        logic wrong;
        if (who == 1) p1_hit_req = 1'b1; else p2_hit_req = 1'b1;
        wait_ack(who, ok, landed, wrong);
        p1_hit_req = 1'b0;
        p2_hit_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic reload();
        game_state = 3'd1;
        tick();
        tick();
        game_state = 3'd2;
    endtask

    initial begin
        logic ok, landed, wrong;
        int   cnt;

        // who, blocks, wait, landed, h1, h2
        vecs[0]  = '{3'd2, 1, 1'b0, 1'b0, 0,  1'b1, 5, 4};
        vecs[1]  = '{3'd2, 1, 1'b0, 1'b0, 35, 1'b1, 5, 3};
        vecs[2]  = '{3'd2, 1, 1'b0, 1'b0, 35, 1'b1, 5, 2};
        vecs[3]  = '{3'd2, 1, 1'b0, 1'b0, 35, 1'b1, 5, 1};
        vecs[4]  = '{3'd2, 1, 1'b0, 1'b0, 35, 1'b1, 5, 0};
        vecs[5]  = '{3'd3, 1, 1'b0, 1'b0, 35, 1'b0, 5, 0};
        vecs[6]  = '{3'd2, 1, 1'b0, 1'b0, 2,  1'b0, 5, 0};
        vecs[7]  = '{3'd0, 2, 1'b0, 1'b0, 0,  1'b0, 5, 0};
        vecs[8]  = '{3'd1, 2, 1'b0, 1'b0, 1,  1'b0, 5, 5};
        vecs[9]  = '{3'd2, 1, 1'b0, 1'b1, 0,  !GUARD, 5, GUARD ? 5 : 4};
        vecs[10] = '{3'd2, 2, 1'b0, 1'b1, 0,  1'b1, 4, GUARD ? 5 : 4};
        vecs[11] = '{3'd2, 2, 1'b1, 1'b0, 35, !GUARD, GUARD ? 4 : 3, GUARD ? 5 : 4};

        reset = 1'b0; game_state = 3'd0;
        p1_hit_req = 1'b0; p2_hit_req = 1'b0; p1_block = 1'b0; p2_block = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_h1", player1_health, 5);
        check("rst_h2", player2_health, 5);
        check("rst_acks", {p1_hit_ack, p2_hit_ack}, 0);
        check("rst_landed", hit_landed, 0);
        check("rst_invuln", {p1_invuln, p2_invuln}, 0);
        reset = 1'b1;

        // Latency and invulnerability window length
        reload();
        p1_hit_req = 1'b1;
        tick();
        check("lat_ack_n1", p1_hit_ack, 0);
        tick();
        check("lat_ack_n2", p1_hit_ack, 1);
        check("lat_landed", hit_landed, 1);
        check("lat_h2", player2_health, 4);
        check("lat_p2_ack", p2_hit_ack, 0);
        p1_hit_req = 1'b0;
        cnt = p2_invuln ? 1 : 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (i == 0) check("ack_pulse", p1_hit_ack, 0);
            if (!p2_invuln) break;
            cnt++;
        end
        check("invuln_len", cnt, 30);
        check("p1_invuln_idle", p1_invuln, 0);

        // Tie from reset: P1 first, then P2; next tie goes to P2
        reset = 1'b0; tick(); reset = 1'b1;
        reload();
        p1_hit_req = 1'b1; p2_hit_req = 1'b1;
        wait_ack(1, ok, landed, wrong);
        check("tie1_p1_ack", ok, 1);
        check("tie1_order", wrong, 0);
        check("tie1_landed", landed, 1);
        p1_hit_req = 1'b0;
        wait_ack(2, ok, landed, wrong);
        check("tie1_p2_ack", ok, 1);
        check("tie1_p2_landed", landed, 1);
        p2_hit_req = 1'b0;
        tick(); tick();
        check("tie1_h1", player1_health, 4);
        check("tie1_h2", player2_health, 4);
        p1_hit_req = 1'b1; p2_hit_req = 1'b1;
        wait_ack(2, ok, landed, wrong);
        check("tie2_p2_ack", ok, 1);
        check("tie2_order", wrong, 0);
        p2_hit_req = 1'b0;
        wait_ack(1, ok, landed, wrong);
        check("tie2_p1_ack", ok, 1);
        p1_hit_req = 1'b0;
        tick(); tick();

        // Hit during invulnerability is acked but not landed
        reload();
        hit(1, ok, landed);
        check("inv_first", landed, 1);
        repeat (10) tick();
        hit(1, ok, landed);
        check("inv_ack", ok, 1);
        check("inv_blocked", landed, 0);
        check("inv_h2", player2_health, 4);
        repeat (40) tick();
        hit(1, ok, landed);
        check("inv_expired", landed, 1);
        check("inv_h2b", player2_health, 3);

        // Countdown arriving in the APPLY cycle overrides the damage
        repeat (40) tick();
        reload();
        p1_hit_req = 1'b1;
        tick();
        game_state = 3'd1;
        tick();
        check("cd_ack", p1_hit_ack, 1);
        check("cd_landed", hit_landed, 0);
        check("cd_h2", player2_health, 5);
        p1_hit_req = 1'b0;
        tick(); tick();

        // Reset mid-transaction: no ack
        game_state = 3'd2;
        p1_hit_req = 1'b1;
        tick();
        reset = 1'b0; p1_hit_req = 1'b0;
        tick();
        check("rmid_ack", p1_hit_ack, 0);
        check("rmid_h2", player2_health, 5);
        reset = 1'b1;
        tick();
        check("rmid_ack2", p1_hit_ack, 0);

        // Transaction table
        reload();
        foreach (vecs[k]) begin
            game_state = vecs[k].gs;
            p1_block   = vecs[k].p1_blk;
            p2_block   = vecs[k].p2_blk;
            repeat (vecs[k].pre_wait) tick();
            hit(vecs[k].who, ok, landed);
            check($sformatf("vec%0d_ack", k), ok, 1);
            check($sformatf("vec%0d_landed", k), landed, vecs[k].exp_landed);
            check($sformatf("vec%0d_h1", k), player1_health, vecs[k].exp_h1);
            check($sformatf("vec%0d_h2", k), player2_health, vecs[k].exp_h2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
